// File: rtl/lcd_char_monitor.sv
// lcd_char_monitor: passive receive-side model of an HD44780-style 8-bit LCD bus.
// Decodes instruction and data writes into a 2x16 character image presented as
// two 128-bit line vectors (column 0 in the top byte).
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | waiting for a write edge; the next one is executed
//  BUSY  | executing; counts down, further write edges flag overrun
module lcd_char_monitor #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic         iCLK,
    input  logic         reset,
    input  logic [7:0]   LCD_DATA,
    input  logic         LCD_RW,
    input  logic         LCD_EN,
    input  logic         LCD_RS,
    output logic [127:0] line1,
    output logic [127:0] line2,
    output logic [6:0]   cursor_addr,
    output logic         display_on,
    output logic         busy,
    output logic         overrun,
    output logic         cmd_err,
    output logic         wr_strobe
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES);
    localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES);

    state_t      state, next_state;
    logic [15:0] count;
    logic        en_s1, en_s2, en_s3;
    logic        rs_s1, rs_s2, rw_s1, rw_s2;
    logic [7:0]  data_s1, data_s2;
    logic        inc_mode;
    logic        write_edge, is_clear, accept, overrun_set;

    // DDRAM address step with the two-line wrap (0x27<->0x40, 0x67<->0x00)
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    // Bus synchronizers; all signals share the same depth so they stay aligned with EN
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            en_s3   <= 1'b0;
            rs_s1   <= 1'b0;
            rs_s2   <= 1'b0;
            rw_s1   <= 1'b0;
            rw_s2   <= 1'b0;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            en_s1   <= LCD_EN;
            en_s2   <= en_s1;
            en_s3   <= en_s2;
            rs_s1   <= LCD_RS;
            rs_s2   <= rs_s1;
            rw_s1   <= LCD_RW;
            rw_s2   <= rw_s1;
            data_s1 <= LCD_DATA;
            data_s2 <= data_s1;
        end
    end

    assign write_edge = ~en_s2 & en_s3 & ~rw_s2;
    assign is_clear   = ~rs_s2 & (data_s2 == 8'h01);
    assign busy       = (state == BUSY);

    // Next-state: a write landing on the last busy cycle is taken back-to-back
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (write_edge) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (count == 16'd1) begin
                    if (write_edge) accept = 1'b1;
                    else            next_state = IDLE;
                end else if (write_edge) begin
                    overrun_set = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and busy down-counter
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= 16'd0;
        end else begin
            state <= next_state;
            if (accept)            count <= is_clear ? CLEAR_LOAD : BUSY_LOAD;
            else if (state == BUSY) count <= count - 16'd1;
        end
    end

    // Write execution: character image, cursor and mode flags
    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            line1       <= {16{8'h20}};
            line2       <= {16{8'h20}};
            cursor_addr <= 7'h00;
            inc_mode    <= 1'b1;
            display_on  <= 1'b0;
            overrun     <= 1'b0;
            cmd_err     <= 1'b0;
            wr_strobe   <= 1'b0;
        end else begin
            wr_strobe <= accept;
            if (overrun_set) overrun <= 1'b1;
            if (accept) begin
                if (rs_s2) begin
                    if (cursor_addr[6:4] == 3'b000)
                        line1[{4'd15 - cursor_addr[3:0], 3'b000} +: 8] <= data_s2;
                    else if (cursor_addr[6:4] == 3'b100)
                        line2[{4'd15 - cursor_addr[3:0], 3'b000} +: 8] <= data_s2;
                    cursor_addr <= step_addr(cursor_addr, inc_mode);
                end else begin
                    casez (data_s2)
                        8'b1???????: cursor_addr <= data_s2[6:0];
                        8'b01??????: ;
                        8'b001?????: if (!data_s2[4]) cmd_err <= 1'b1;
                        8'b0001????: if (!data_s2[3]) cursor_addr <= step_addr(cursor_addr, data_s2[2]);
                        8'b00001???: display_on <= data_s2[2];
                        8'b000001??: inc_mode <= data_s2[1];
                        8'b0000001?: cursor_addr <= 7'h00;
                        8'b00000001: begin
                            line1       <= {16{8'h20}};
                            line2       <= {16{8'h20}};
                            cursor_addr <= 7'h00;
                            inc_mode    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_char_monitor.sv
// Scoreboard bench for lcd_char_monitor: stimulus pushes the expected image
// from a character-array reference model; a monitor pops on every wr_strobe.
module tb_lcd_char_monitor;

    localparam int BUSY_N  = 40;
    localparam int CLEAR_N = 1600;

    logic         iCLK = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   LCD_DATA = 8'h00;
    logic         LCD_RW = 1'b0;
    logic         LCD_EN = 1'b0;
    logic         LCD_RS = 1'b0;
    logic [127:0] line1, line2;
    logic [6:0]   cursor_addr;
    logic         display_on, busy, overrun, cmd_err, wr_strobe;

    always #5 iCLK = ~iCLK;

    lcd_char_monitor #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
        .iCLK(iCLK), .reset(reset), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW),
        .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .line1(line1), .line2(line2),
        .cursor_addr(cursor_addr), .display_on(display_on), .busy(busy),
        .overrun(overrun), .cmd_err(cmd_err), .wr_strobe(wr_strobe)
    );

    typedef struct {
        logic [127:0] l1;
        logic [127:0] l2;
        logic [6:0]   cur;
        logic         don;
        logic         cerr;
        logic         ovr;
        int           dur;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: plain character grid plus cursor/mode variables
    logic [7:0] m_disp [2][16];
    int         m_cur;
    bit         m_inc, m_don, m_cerr, m_ovr;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endfunction

    function automatic logic [127:0] img(int r);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[(15 - c) * 8 +: 8] = m_disp[r][c];
        return v;
    endfunction

    function automatic logic [127:0] str_img(string s);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[(15 - i) * 8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
        return v;
    endfunction

    function automatic int step(int a, bit up);
        if (up) begin
            if (a == 'h27) return 'h40;
            if (a == 'h67) return 0;
            return (a + 1) % 128;
        end
        if (a == 0)    return 'h67;
        if (a == 'h40) return 'h27;
        return (a + 127) % 128;
    endfunction

    function automatic void model_blank();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) m_disp[r][c] = 8'h20;
        m_cur = 0;
        m_inc = 1'b1;
    endfunction

    function automatic void model_reset();
        model_blank();
        m_don  = 1'b0;
        m_cerr = 1'b0;
        m_ovr  = 1'b0;
    endfunction

    // returns the busy duration the write should produce
    function automatic int model_apply(bit rs, logic [7:0] d);
        int v = int'(d);
        if (rs) begin
            if (m_cur < 16) m_disp[0][m_cur] = d;
            else if (m_cur >= 64 && m_cur < 80) m_disp[1][m_cur - 64] = d;
            m_cur = step(m_cur, m_inc);
            return BUSY_N;
        end
        if (v >= 128)     m_cur = v - 128;
        else if (v >= 64) ;
        else if (v >= 32) begin if (d[4] == 1'b0) m_cerr = 1'b1; end
        else if (v >= 16) begin if (d[3] == 1'b0) m_cur = step(m_cur, d[2]); end
        else if (v >= 8)  m_don = d[2];
        else if (v >= 4)  m_inc = d[1];
        else if (v >= 2)  m_cur = 0;
        else if (v == 1) begin
            model_blank();
            return CLEAR_N;
        end
        return BUSY_N;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic do_write(bit rs, logic [7:0] d, bit acc);
        exp_t e;
        tick(1);
        LCD_RS = rs;
        LCD_RW = 1'b0;
        LCD_DATA = d;
        if (acc) begin
            e.dur  = model_apply(rs, d);
            e.l1   = img(0);
            e.l2   = img(1);
            e.cur  = 7'(m_cur);
            e.don  = m_don;
            e.cerr = m_cerr;
            e.ovr  = m_ovr;
            sb.push_back(e);
        end else begin
            m_ovr = 1'b1;
        end
        tick(4);
        LCD_EN = 1'b1;
        tick(3);
        LCD_EN = 1'b0;
        tick(2);
    endtask

    task automatic wait_idle();
        int n = 0;
        tick(6);
        while (busy === 1'b1 && n < 5000) begin
            tick(1);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        tick(2);
    endtask

    task automatic wr(bit rs, logic [7:0] d);
        do_write(rs, d, 1'b1);
        wait_idle();
    endtask

    task automatic wr_str(string s);
        for (int i = 0; i < s.len(); i++) wr(1'b1, s[i]);
    endtask

    // monitor: pop on each write strobe, then measure the busy pulse length
    exp_t cur_e;
    bit   counting = 1'b0;
    int   mon_cnt = 0;
    always @(negedge iCLK) begin
        if (reset) begin
            counting = 1'b0;
        end else begin
            if (counting) begin
                if (busy) mon_cnt++;
                else begin
                    chk("busy_len", 128'(mon_cnt), 128'(cur_e.dur));
                    counting = 1'b0;
                end
            end
            if (wr_strobe) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe: unexpected wr_strobe at %0t, none expected", $time);
                end else begin
                    cur_e = sb.pop_front();
                    chk("line1", line1, cur_e.l1);
                    chk("line2", line2, cur_e.l2);
                    chk("cursor", 128'(cursor_addr), 128'(cur_e.cur));
                    chk("display_on", 128'(display_on), 128'(cur_e.don));
                    chk("cmd_err", 128'(cmd_err), 128'(cur_e.cerr));
                    chk("overrun", 128'(overrun), 128'(cur_e.ovr));
                    chk("busy_at_strobe", 128'(busy), 128'(1'b1));
                    counting = 1'b1;
                    mon_cnt = 1;
                end
            end
        end
    end

    initial begin
        #900000;
        checks++;
        errors++;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [7:0] d;
        int         r;
        model_reset();
        tick(3);
        chk("rst_line1", line1, str_img(""));
        chk("rst_line2", line2, str_img(""));
        chk("rst_cursor", 128'(cursor_addr), 128'(7'h00));
        chk("rst_flags", 128'({display_on, busy, overrun, cmd_err, wr_strobe}), 128'(5'b0));
        reset = 1'b0;
        tick(2);

        // init sequence and first message
        wr(1'b0, 8'h38);
        wr(1'b0, 8'h0C);
        wr(1'b0, 8'h06);
        wr(1'b0, 8'h01);
        wr_str("Armed");
        chk("armed_don", 128'(display_on), 128'(1'b1));
        chk("armed_line1", line1, str_img("Armed"));
        chk("armed_line2", line2, str_img(""));
        chk("armed_cursor", 128'(cursor_addr), 128'(7'h05));

        wr(1'b0, 8'hC0);
        wr_str("Enter Pass Key  ");
        chk("pass_line2", line2, str_img("Enter Pass Key"));
        chk("pass_line1", line1, str_img("Armed"));
        chk("pass_cursor", 128'(cursor_addr), 128'(7'h50));

        // end of line 1, off-screen write, wrap 0x27 -> 0x40
        wr(1'b0, 8'h8F);
        wr(1'b1, "A");
        chk("col15_A", 128'(line1[7:0]), 128'(8'h41));
        chk("cursor_10", 128'(cursor_addr), 128'(7'h10));
        wr(1'b1, "B");
        chk("cursor_11", 128'(cursor_addr), 128'(7'h11));
        chk("B_discard", line1, str_img("Armed          A"));
        wr(1'b0, 8'hA7);
        wr(1'b1, "x");
        chk("wrap_40", 128'(cursor_addr), 128'(7'h40));

        // overrun: second write ~10 cycles into the first one's busy window
        do_write(1'b1, "Q", 1'b1);
        do_write(1'b1, "R", 1'b0);
        wait_idle();
        chk("overrun_set", 128'(overrun), 128'(1'b1));
        chk("ovr_line2", line2, str_img("Qnter Pass Key"));
        chk("ovr_cursor", 128'(cursor_addr), 128'(7'h41));

        // function set DL bit
        wr(1'b0, 8'h30);
        chk("cmd_err_0", 128'(cmd_err), 128'(1'b0));
        wr(1'b0, 8'h20);
        chk("cmd_err_1", 128'(cmd_err), 128'(1'b1));

        // read strobe carrying a clear pattern must be ignored
        tick(1);
        LCD_RS = 1'b0;
        LCD_RW = 1'b1;
        LCD_DATA = 8'h01;
        tick(4);
        LCD_EN = 1'b1;
        tick(3);
        LCD_EN = 1'b0;
        tick(8);
        chk("read_busy", 128'(busy), 128'(1'b0));
        chk("read_cursor", 128'(cursor_addr), 128'(m_cur));
        chk("read_line1", line1, img(0));

        // randomized mix of data and instructions
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                wr(1'b1, 8'($urandom_range(32, 126)));
            end else begin
                if (r < 70) begin
                    case ($urandom_range(0, 4))
                        0: d = 8'h80 | 8'($urandom_range(0, 15));
                        1: d = 8'hC0 | 8'($urandom_range(0, 15));
                        2: d = 8'h80 | 8'($urandom_range(32, 39));
                        3: d = 8'h80 | 8'($urandom_range(96, 103));
                        default: d = 8'h80 | 8'($urandom_range(0, 127));
                    endcase
                end else if (r < 76) d = 8'h04 | 8'($urandom_range(0, 3));
                else if (r < 83) d = 8'h10 | 8'($urandom_range(0, 15));
                else if (r < 88) d = 8'h08 | 8'($urandom_range(0, 7));
                else if (r < 90) d = 8'h02 | 8'($urandom_range(0, 1));
                else if (r < 92) d = 8'h00;
                else if (r < 94) d = 8'h40 | 8'($urandom_range(0, 63));
                else if (r < 97) d = 8'h20 | 8'($urandom_range(0, 31));
                else d = 8'h01;
                wr(1'b0, d);
            end
        end
        chk("rand_line1", line1, img(0));
        chk("rand_line2", line2, img(1));

        // reset during clear busy
        do_write(1'b0, 8'h01, 1'b1);
        tick(100);
        chk("clear_busy", 128'(busy), 128'(1'b1));
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 128'(busy), 128'(1'b0));
        chk("rst_mid_line1", line1, str_img(""));
        chk("rst_mid_line2", line2, str_img(""));
        chk("rst_mid_flags", 128'({overrun, cmd_err, display_on, cursor_addr}), 128'(10'b0));
        model_reset();
        tick(3);
        reset = 1'b0;
        tick(1);
        wr(1'b1, "Z");
        chk("post_rst_line1", line1, str_img("Z"));
        chk("post_rst_cursor", 128'(cursor_addr), 128'(7'h01));

        tick(5);
        chk("queue_empty", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
